// File: rtl/morse_pkg.sv
// ============================================================================
// Module      : morse_pkg
// Description : Shared definitions for the Morse transmit sequencer:
//               sequencer state encoding and parameter defaults.
//               UNIT_BCD_W may be predefined to widen the timing inputs;
//               the timing width default is four bits per BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef UNIT_BCD_W
`define UNIT_BCD_W 6
`endif

package morse_pkg;

  localparam int MAX_ELEMS_DEF = 6;
  localparam int CNT_W_DEF     = `UNIT_BCD_W * 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// ============================================================================
// Module      : morse_unit_timer
// Description : Prescaler plus unit down-counter. A load pulse restarts both
//               counters; done is high during the final clock cycle of a
//               units*P cycle interval and stays high until the next load.
// Ports       : clk, rst_n    - clock, async active-low reset
//               load_i        - restart interval (same edge as state entry)
//               units_i       - interval length in units (must be >= 1)
//               p_i           - clk cycles per unit (must be >= 1)
//               done_o        - last cycle of the interval
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] units_i,
  input  logic [CNT_W-1:0] p_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] ucnt_q;

  // Both counters hold "remaining minus one", so done lands on the last cycle
  // and the owning state lasts exactly units*P cycles.
  assign done_o = (pcnt_q == '0) && (ucnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      pcnt_q <= '0;
      ucnt_q <= '0;
    end else if (load_i) begin
      p_q    <= p_i;
      pcnt_q <= p_i - ONE;
      ucnt_q <= units_i - ONE;
    end else if (pcnt_q != '0) begin
      pcnt_q <= pcnt_q - ONE;
    end else if (ucnt_q != '0) begin
      ucnt_q <= ucnt_q - ONE;
      pcnt_q <= p_q - ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/morse_tx_sequencer.sv
// ============================================================================
// Module      : morse_tx_sequencer
// Description : Keys one Morse symbol at a time. A symbol is a list of up to
//               MAX_ELEMS dit/dah marks, or a word space. Marks are separated
//               by pause gaps and the symbol ends with a character gap.
//               Build option MORSE_ABORT_EN adds an 'abort' input that returns
//               the sequencer to IDLE with the key released.
// Ports       : clk, rst_n              - clock, async active-low reset
//               dit/dah/pause/char/word_units - durations in units
//               pulses_per_unit        - clk cycles per unit
//               sym_valid/sym_ready    - symbol handshake
//               sym_pattern, sym_len   - elements (bit i, 1 = dah), count
//               sym_space              - word gap instead of marks
//               key_out                - registered key, high during marks
//               busy                   - not IDLE
//               abort (MORSE_ABORT_EN) - cancel the symbol in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_ELEMS = MAX_ELEMS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_W-1:0]     dit_units,
  input  logic [CNT_W-1:0]     dah_units,
  input  logic [CNT_W-1:0]     pause_units,
  input  logic [CNT_W-1:0]     char_units,
  input  logic [CNT_W-1:0]     word_units,
  input  logic [CNT_W-1:0]     pulses_per_unit,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [MAX_ELEMS-1:0] sym_pattern,
  input  logic [2:0]           sym_len,
`ifdef MORSE_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 sym_space,
  output logic                 key_out,
  output logic                 busy
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_ELEMS);

  state_e               state_q;
  logic                 key_q;
  logic                 busy_q;
  logic                 ready_q;
  logic [MAX_ELEMS-1:0] pattern_q;
  logic [2:0]           len_q;
  logic [2:0]           elem_q;
  logic [CNT_W-1:0]     dit_q, dah_q, pause_q, char_q, word_q, ppu_q;

  logic                 w_accept;
  logic                 w_done;
  logic                 w_load;
  logic [CNT_W-1:0]     w_units;
  logic [CNT_W-1:0]     w_p;
  logic [2:0]           w_len;
  logic [2:0]           w_next_elem;
  logic                 w_more;
  logic                 w_next_bit;

  // A zero duration is taken as one unit.
  function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

`ifdef MORSE_ABORT_EN
  assign w_accept = sym_valid & ready_q & ~abort;
`else
  assign w_accept = sym_valid & ready_q;
`endif

  assign w_len       = (sym_len > MAX_LEN) ? MAX_LEN : sym_len;
  assign w_next_elem = elem_q + 3'd1;
  assign w_more      = (w_next_elem < len_q);
  assign w_next_bit  = |(pattern_q & (MAX_ELEMS'(1) << w_next_elem));

  assign sym_ready = ready_q;
  assign busy      = busy_q;
  assign key_out   = key_q;

  // The timer is reloaded on the same edge that enters a timed state. At
  // accept the latched copies are not yet valid, so the live inputs are used.
  always_comb begin
    w_load  = 1'b0;
    w_units = '0;
    w_p     = ppu_q;
    if (w_accept) begin
      w_load = 1'b1;
      w_p    = min1(pulses_per_unit);
      if (sym_space)          w_units = min1(word_units);
      else if (w_len == 3'd0) w_units = min1(char_units);
      else                    w_units = sym_pattern[0] ? min1(dah_units) : min1(dit_units);
    end else if (w_done) begin
      case (state_q)
        MARK: begin
          w_load  = 1'b1;
          w_units = w_more ? pause_q : char_q;
        end
        GAP: begin
          w_load  = 1'b1;
          w_units = w_next_bit ? dah_q : dit_q;
        end
        default: ;
      endcase
    end
  end

  morse_unit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_load),
    .units_i (w_units),
    .p_i     (w_p),
    .done_o  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      pattern_q <= '0;
      len_q     <= '0;
      elem_q    <= '0;
      dit_q     <= '0;
      dah_q     <= '0;
      pause_q   <= '0;
      char_q    <= '0;
      word_q    <= '0;
      ppu_q     <= '0;
`ifdef MORSE_ABORT_EN
    end else if (abort) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            pattern_q <= sym_pattern;
            len_q     <= w_len;
            elem_q    <= '0;
            dit_q     <= min1(dit_units);
            dah_q     <= min1(dah_units);
            pause_q   <= min1(pause_units);
            char_q    <= min1(char_units);
            word_q    <= min1(word_units);
            ppu_q     <= min1(pulses_per_unit);
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (sym_space) begin
              state_q <= WORD_GAP;
            end else if (w_len == 3'd0) begin
              state_q <= CHAR_GAP;
            end else begin
              state_q <= MARK;
              key_q   <= 1'b1;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            ready_q <= 1'b1;
          end
        end
        MARK: begin
          if (w_done) begin
            key_q   <= 1'b0;
            state_q <= w_more ? GAP : CHAR_GAP;
          end
        end
        GAP: begin
          if (w_done) begin
            elem_q  <= w_next_elem;
            key_q   <= 1'b1;
            state_q <= MARK;
          end
        end
        CHAR_GAP, WORD_GAP: begin
          if (w_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          key_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_morse_tx_sequencer.sv
// ============================================================================
// Module      : tb_morse_tx_sequencer
// Description : Directed self-checking bench for morse_tx_sequencer.
//               Inputs change on the falling edge; outputs are sampled on the
//               falling edge, so sample k reflects the state after the k-th
//               rising edge following an accept. Define MORSE_ABORT_EN to
//               also exercise the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_tx_sequencer;
  import morse_pkg::*;

  localparam int CW = CNT_W_DEF;
  localparam int ME = MAX_ELEMS_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] dit_units, dah_units, pause_units, char_units, word_units;
  logic [CW-1:0] pulses_per_unit;
  logic          sym_valid;
  logic          sym_ready;
  logic [ME-1:0] sym_pattern;
  logic [2:0]    sym_len;
  logic          sym_space;
  logic          key_out;
  logic          busy;
`ifdef MORSE_ABORT_EN
  logic          abort = 1'b0;
`endif

  int nvec = 0;
  int nmis = 0;

  morse_tx_sequencer #(
    .MAX_ELEMS (ME),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dit_units       (dit_units),
    .dah_units       (dah_units),
    .pause_units     (pause_units),
    .char_units      (char_units),
    .word_units      (word_units),
    .pulses_per_unit (pulses_per_unit),
    .sym_valid       (sym_valid),
    .sym_ready       (sym_ready),
    .sym_pattern     (sym_pattern),
    .sym_len         (sym_len),
`ifdef MORSE_ABORT_EN
    .abort           (abort),
`endif
    .sym_space       (sym_space),
    .key_out         (key_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check key and busy for n consecutive samples, advancing one cycle each.
  task automatic expect_kb(input string tag, input int n, input logic k, input logic b);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_key[%0d]", tag, i), key_out, k);
      chk($sformatf("%s_busy[%0d]", tag, i), busy, b);
      @(negedge clk);
    end
  endtask

  // Present a symbol for exactly one accept edge.
  task automatic offer(input logic space, input logic [ME-1:0] pat, input logic [2:0] len);
    sym_space   = space;
    sym_pattern = pat;
    sym_len     = len;
    sym_valid   = 1'b1;
    @(negedge clk);
    sym_valid   = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_ready"}, sym_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_key"}, key_out, 1'b0);
  endtask

  initial begin
    dit_units       = 2;
    dah_units       = 6;
    pause_units     = 2;
    char_units      = 6;
    word_units      = 14;
    pulses_per_unit = 1;
    sym_valid       = 1'b0;
    sym_pattern     = '0;
    sym_len         = '0;
    sym_space       = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_key", key_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", sym_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("post_rst");

    // 'A' with sym_valid held high for the whole symbol: one accept only
    sym_space   = 1'b0;
    sym_pattern = 6'b000010;
    sym_len     = 3'd2;
    sym_valid   = 1'b1;
    @(negedge clk);
    chk("A_ready_low", sym_ready, 1'b0);
    expect_kb("A_m0", 2, 1'b1, 1'b1);
    expect_kb("A_g0", 2, 1'b0, 1'b1);
    expect_kb("A_m1", 6, 1'b1, 1'b1);
    expect_kb("A_cg", 6, 1'b0, 1'b1);
    expect_idle("A_end");
    sym_valid = 1'b0;
    @(negedge clk);
    expect_idle("A_end2");

    // Word space: pattern and length ignored
    offer(1'b1, 6'b111111, 3'd3);
    sym_space = 1'b0;
    expect_kb("W", 14, 1'b0, 1'b1);
    expect_idle("W_end");

    // 'E' at P=3; P changed after accept must not matter
    pulses_per_unit = 3;
    offer(1'b0, 6'b000000, 3'd1);
    pulses_per_unit = 1;
    expect_kb("E3_m", 6, 1'b1, 1'b1);
    expect_kb("E3_cg", 18, 0, 1'b1);
    expect_idle("E3_end");

    // 'T' with dah_units changed mid-mark
    offer(1'b0, 6'b000001, 3'd1);
    dah_units = 1;
    expect_kb("T_m", 6, 1'b1, 1'b1);
    expect_kb("T_cg", 6, 1'b0, 1'b1);
    expect_idle("T_end");
    dah_units = 6;

    // Zero-length symbol goes straight to the character gap
    offer(1'b0, 6'b111111, 3'd0);
    expect_kb("L0", 6, 1'b0, 1'b1);
    expect_idle("L0_end");

    // Zero dit duration is treated as one unit
    dit_units = 0;
    offer(1'b0, 6'b000000, 3'd1);
    dit_units = 2;
    expect_kb("D0_m", 1, 1'b1, 1'b1);
    expect_kb("D0_cg", 6, 1'b0, 1'b1);
    expect_idle("D0_end");

    // Length 7 clamps to six elements: five dits then a dah
    offer(1'b0, 6'b100000, 3'd7);
    for (int e = 0; e < 5; e++) begin
      expect_kb($sformatf("L7_m%0d", e), 2, 1'b1, 1'b1);
      expect_kb($sformatf("L7_g%0d", e), 2, 1'b0, 1'b1);
    end
    expect_kb("L7_m5", 6, 1'b1, 1'b1);
    expect_kb("L7_cg", 6, 1'b0, 1'b1);
    expect_idle("L7_end");

    // Reset in the middle of a mark
    offer(1'b0, 6'b000001, 3'd1);
    expect_kb("R_m", 3, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("R_async_key", key_out, 1'b0);
    chk("R_async_busy", busy, 1'b0);
    chk("R_async_ready", sym_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("R_rel");
    expect_kb("R_after", 8, 1'b0, 1'b0);

`ifdef MORSE_ABORT_EN
    // One-cycle abort during the first gap of 'A'
    offer(1'b0, 6'b000010, 3'd2);
    expect_kb("AB_m0", 2, 1'b1, 1'b1);
    chk("AB_gap_key", key_out, 1'b0);
    chk("AB_gap_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_idle("AB_next");
    expect_kb("AB_after", 10, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/morse_tx_sequencer.md
MORSE_TX_SEQUENCER -- requirements
Module: morse_tx_sequencer

Interface
REQ-001 SHALL have parameter MAX_ELEMS, default 6: maximum marks per symbol.
REQ-002 SHALL have parameter CNT_W, default `UNIT_BCD_W*4 (24): width of all timing inputs.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports dit_units, dah_units, pause_units, char_units, word_units, input, CNT_W: durations in units, unsigned binary.
REQ-006 SHALL have port pulses_per_unit, input, CNT_W: clk cycles per unit.
REQ-007 SHALL have port sym_valid, input, 1: symbol offered.
REQ-008 SHALL have port sym_ready, output, 1: sequencer can accept a symbol.
REQ-009 SHALL have port sym_pattern, input, MAX_ELEMS: bit i is element i (first = bit 0); 1 = dah, 0 = dit.
REQ-010 SHALL have port sym_len, input, 3: element count.
REQ-011 SHALL have port sym_space, input, 1: word gap, no marks.
REQ-012 SHALL have port key_out, output, 1: registered key, high during marks.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL use states IDLE, MARK, GAP, CHAR_GAP, WORD_GAP.
REQ-015 SHALL assert sym_ready only in IDLE; accept occurs on the edge where sym_valid and sym_ready are both high.
REQ-016 SHALL latch sym_pattern, sym_len and all six timing inputs at accept; later input changes SHALL NOT affect the symbol in progress.
REQ-017 SHALL restart the prescaler at accept and at every state entry, so each unit is exactly P = pulses_per_unit cycles.
REQ-018 SHALL treat any latched timing value of 0 as 1.
REQ-019 SHALL, on accept with sym_space=1, enter WORD_GAP for word_units units with key_out low; sym_pattern and sym_len are ignored.
REQ-020 SHALL, on accept with sym_space=0 and sym_len>0, enter MARK for element 0.
REQ-021 SHALL treat sym_len>MAX_ELEMS as MAX_ELEMS.
REQ-022 SHALL, on accept with sym_space=0 and sym_len=0, enter CHAR_GAP directly.
REQ-023 SHALL hold MARK for dit_units or dah_units units, selected by the element bit.
REQ-024 SHALL go from MARK to GAP (pause_units units) if elements remain, otherwise to CHAR_GAP (char_units units); gaps are total gaps, not additive.
REQ-025 SHALL go from GAP to MARK of the next element, and from CHAR_GAP or WORD_GAP to IDLE.
REQ-026 SHALL register key_out: high in the cycle after MARK entry; duration exactly N*P cycles.
REQ-027 SHALL NOT let sym_valid held high in IDLE start a second accept before the current symbol returns to IDLE.

Reset
REQ-028 SHALL, while rst_n is low, force state=IDLE, key_out=0, busy=0, sym_ready=0, counters=0 and latched registers=0.
REQ-029 SHALL assert sym_ready in the first cycle after rst_n deasserts.
REQ-030 SHALL, on reset mid-symbol, drop key_out immediately and discard the symbol.

Configuration
REQ-031 SHALL, with MORSE_ABORT_EN defined, add input abort (1 bit); abort high in any state gives key_out=0 and IDLE on the next edge, and abort takes priority over accept.
REQ-032 SHALL, without MORSE_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-033 SHALL place the state encoding, MAX_ELEMS and CNT_W defaults in shared package morse_pkg.
REQ-034 SHALL implement the prescaler and unit down-counter as sub-module morse_unit_timer (inputs: load, units, P; output: done).

Verification (all cases P=1, dit=2, dah=6, pause=2, char=6, word=14 unless stated)
REQ-035 SHALL cover 'A' (pattern=...10, len=2): key high 2, low 2, high 6, low 6; sym_ready returns 16 cycles after key rise.
REQ-036 SHALL cover sym_space=1: key stays 0; busy high 14 cycles; then sym_ready=1.
REQ-037 SHALL cover P=3 with 'E' (len=1, dit): key high 6 cycles, low 18 cycles.
REQ-038 SHALL cover dah_units changed from 6 to 1 mid-'T': the mark still lasts 6 cycles.
REQ-039 SHALL cover rst_n low mid-MARK: key_out is 0 asynchronously; after release sym_ready=1 and the prior symbol is not resumed.
REQ-040 SHALL cover, with MORSE_ABORT_EN, a 1-cycle abort during GAP of 'A': IDLE on the next edge and no further marks.
